// File: rtl/sargantana_icache_ctrl_nb.sv
// Non-blocking instruction-cache control FSM.
// Sequences lookup, TLB-miss wait, line-fill miss, replay and kill for the
// fetch stage. Killed misses leave their fill slot outstanding as a stale
// entry, so new lookups proceed with up to MAX_MISS fills in flight.
// Ports:
//   clk_i, rstn_i                      clock, async active-low reset
//   req_valid_i/req_idx_i/req_kill_i   fetch lookup request and kill
//   req_ready_o                        controller accepts a request
//   tlb_valid_i/tlb_miss_i/tlb_ptag_i  iTLB translation result
//   hit_i                              tag compare hit for latched index
//   resp_valid_o                       hit data valid to fetch
//   fill_req_*                         line-fill request to L2
//   fill_rsp_valid_i/fill_rsp_id_i     line-fill response from L2
//   fill_we_o/fill_idx_o               array write of returned line
//   state_o, outstanding_o             current state, busy slot count
module sargantana_icache_ctrl_nb #(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned TAG_W    = 20,
    parameter int unsigned MAX_MISS = 2,
    parameter int unsigned ID_W     = (MAX_MISS > 1) ? $clog2(MAX_MISS) : 1,
    localparam int unsigned CNT_W   = $clog2(MAX_MISS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   req_valid_i,
    input  logic [IDX_W-1:0]       req_idx_i,
    input  logic                   req_kill_i,
    output logic                   req_ready_o,
    input  logic                   tlb_valid_i,
    input  logic                   tlb_miss_i,
    input  logic [TAG_W-1:0]       tlb_ptag_i,
    input  logic                   hit_i,
    output logic                   resp_valid_o,
    output logic                   fill_req_valid_o,
    input  logic                   fill_req_ready_i,
    output logic [TAG_W+IDX_W-1:0] fill_req_addr_o,
    output logic [ID_W-1:0]        fill_req_id_o,
    input  logic                   fill_rsp_valid_i,
    input  logic [ID_W-1:0]        fill_rsp_id_i,
    output logic                   fill_we_o,
    output logic [IDX_W-1:0]       fill_idx_o,
    output logic [2:0]             state_o,
    output logic [CNT_W-1:0]       outstanding_o
);

    typedef enum logic [2:0] {
        NO_REQ     = 3'd0,
        READ       = 3'd1,
        MISS       = 3'd2,
        TLB_MISS   = 3'd3,
        REPLAY     = 3'd4,
        KILL       = 3'd5,
        REPLAY_TLB = 3'd6,
        KILL_TLB   = 3'd7
    } ictrl_state_t;

    ictrl_state_t                     state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [TAG_W-1:0]                 ptag_q, ptag_d;
    logic                             issued_q, issued_d;
    logic [ID_W-1:0]                  cur_id_q, cur_id_d;
    logic [MAX_MISS-1:0]              busy_q, busy_d;
    logic [MAX_MISS-1:0]              live_q, live_d;
    logic [MAX_MISS-1:0][IDX_W-1:0]   slot_idx_q, slot_idx_d;
    logic [CNT_W-1:0]                 count_q, count_d;

    logic                             free_found;
    logic [ID_W-1:0]                  free_id;
    logic                             rsp_busy;
    logic                             rsp_live;
    logic                             alloc;

    // State and slot table registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= NO_REQ;
            idx_q      <= '0;
            ptag_q     <= '0;
            issued_q   <= 1'b0;
            cur_id_q   <= '0;
            busy_q     <= '0;
            live_q     <= '0;
            slot_idx_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptag_q     <= ptag_d;
            issued_q   <= issued_d;
            cur_id_q   <= cur_id_d;
            busy_q     <= busy_d;
            live_q     <= live_d;
            slot_idx_q <= slot_idx_d;
            count_q    <= count_d;
        end
    end

    // Next state, slot bookkeeping and handshake outputs
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        ptag_d           = ptag_q;
        issued_d         = issued_q;
        cur_id_d         = cur_id_q;
        busy_d           = busy_q;
        live_d           = live_q;
        slot_idx_d       = slot_idx_q;
        req_ready_o      = 1'b0;
        resp_valid_o     = 1'b0;
        fill_req_valid_o = 1'b0;
        fill_idx_o       = '0;
        free_found       = 1'b0;
        free_id          = '0;
        rsp_busy         = 1'b0;
        rsp_live         = 1'b0;
        alloc            = 1'b0;

        // Lowest free slot; uses registered busy so a slot freed this cycle waits
        for (int i = MAX_MISS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_id    = ID_W'(i);
            end
        end

        // Fill response on a busy slot is written in any state and frees the slot
        for (int i = 0; i < MAX_MISS; i++) begin
            if (fill_rsp_valid_i && fill_rsp_id_i == ID_W'(i) && busy_q[i]) begin
                rsp_busy   = 1'b1;
                rsp_live   = live_q[i];
                fill_idx_o = slot_idx_q[i];
                busy_d[i]  = 1'b0;
                live_d[i]  = 1'b0;
            end
        end
        fill_we_o = rsp_busy;

        case (state_q)
            NO_REQ: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    idx_d   = req_idx_i;
                    state_d = READ;
                end
            end
            READ: begin
                if (req_kill_i) begin
                    state_d = KILL;
                end else if (tlb_valid_i) begin
                    if (tlb_miss_i) begin
                        state_d = TLB_MISS;
                    end else if (hit_i) begin
                        resp_valid_o = 1'b1;
                        state_d      = NO_REQ;
                    end else begin
                        ptag_d   = tlb_ptag_i;
                        issued_d = 1'b0;
                        state_d  = MISS;
                    end
                end
            end
            MISS: begin
                if (req_kill_i) begin
                    // An issued fill stays outstanding but no longer replays
                    if (issued_q) begin
                        for (int i = 0; i < MAX_MISS; i++) begin
                            if (cur_id_q == ID_W'(i)) begin
                                live_d[i] = 1'b0;
                            end
                        end
                    end
                    state_d = KILL;
                end else begin
                    if (!issued_q && free_found) begin
                        fill_req_valid_o = 1'b1;
                        if (fill_req_ready_i) begin
                            alloc    = 1'b1;
                            issued_d = 1'b1;
                            cur_id_d = free_id;
                            for (int i = 0; i < MAX_MISS; i++) begin
                                if (free_id == ID_W'(i)) begin
                                    busy_d[i]     = 1'b1;
                                    live_d[i]     = 1'b1;
                                    slot_idx_d[i] = idx_q;
                                end
                            end
                        end
                    end
                    if (rsp_busy && rsp_live) begin
                        state_d = REPLAY;
                    end
                end
            end
            TLB_MISS: begin
                if (req_kill_i) begin
                    state_d = KILL_TLB;
                end else if (tlb_valid_i && !tlb_miss_i) begin
                    state_d = REPLAY_TLB;
                end
            end
            REPLAY, REPLAY_TLB: begin
                state_d = req_kill_i ? KILL : READ;
            end
            KILL, KILL_TLB: begin
                state_d = NO_REQ;
            end
            default: begin
                state_d = NO_REQ;
            end
        endcase

        count_d = count_q + CNT_W'(alloc) - CNT_W'(rsp_busy);
    end

    assign fill_req_addr_o = {ptag_q, idx_q};
    assign fill_req_id_o   = free_id;
    assign state_o         = state_q;
    assign outstanding_o   = count_q;

    // Responses must target a slot that has an outstanding fill
    rsp_on_busy_slot: assert property (@(posedge clk_i) disable iff (!rstn_i)
        fill_rsp_valid_i |-> rsp_busy);

endmodule

// File: doc/sargantana_icache_ctrl_nb.md
# sargantana_icache_ctrl_nb

Non-blocking instruction-cache control FSM, the parametrised successor of the single-miss `ictrl_state_t` controller. It sequences lookup, TLB-miss wait, line-fill miss, replay and kill for the fetch stage. Killed misses no longer stall the cache: their fill slots stay outstanding as stale entries while new lookups proceed, up to `MAX_MISS` in flight. It sits between the fetch stage, the iTLB, the tag/data arrays and the L2 fill interface.

## Interface
- `IDX_W`, 6: set-index width.
- `TAG_W`, 20: physical tag width.
- `MAX_MISS`, 2: outstanding fill slots, legal range 1..4.
- `ID_W`, max(1,$clog2(MAX_MISS)): fill-ID width.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  1  fetch lookup request.
- `req_idx_i`  in  IDX_W  set index of the request.
- `req_kill_i`  in  1  kill current request (flush/redirect).
- `req_ready_o`  out  1  controller can accept a request.
- `tlb_valid_i`  in  1  translation result valid.
- `tlb_miss_i`  in  1  translation missed (qualified by `tlb_valid_i`).
- `tlb_ptag_i`  in  TAG_W  physical tag.
- `hit_i`  in  1  array tag compare hit for the latched index.
- `resp_valid_o`  out  1  hit data valid to fetch.
- `fill_req_valid_o`  out  1  line-fill request.
- `fill_req_ready_i`  in  1  L2 accepts the fill request.
- `fill_req_addr_o`  out  TAG_W+IDX_W  {ptag, idx} of the line.
- `fill_req_id_o`  out  ID_W  slot ID.
- `fill_rsp_valid_i`  in  1  fill data returned.
- `fill_rsp_id_i`  in  ID_W  slot ID of the response.
- `fill_we_o`  out  1  write returned line into arrays.
- `fill_idx_o`  out  IDX_W  set index for the array write.
- `state_o`  out  3  current state, `ictrl_state_t` encoding.
- `outstanding_o`  out  $clog2(MAX_MISS+1)  busy slot count.

## Operation
- State encoding: NO_REQ=0, READ=1, MISS=2, TLB_MISS=3, REPLAY=4, KILL=5, REPLAY_TLB=6, KILL_TLB=7.
- Slot table: per slot {busy, live, idx}. Allocation uses the lowest free slot at the fill-request handshake.
- NO_REQ:
  - `req_ready_o`=1.
  - `req_valid_i` latches `req_idx_i` and moves to READ.
  - `req_kill_i` is ignored.
- READ:
  - Kill → KILL.
  - `!tlb_valid_i` → stay in READ.
  - TLB miss → TLB_MISS.
  - Hit → `resp_valid_o`=1 for this cycle, then NO_REQ.
  - Otherwise latch `tlb_ptag_i` → MISS.
- MISS:
  - `fill_req_valid_o`=1 while no slot has been issued and a free slot exists. It holds until `fill_req_ready_i`, then the slot is marked busy and live.
  - Kill before the handshake: `fill_req_valid_o` deasserts the same cycle, no slot is allocated, → KILL.
  - Kill after the handshake: the slot becomes stale (live=0), → KILL.
  - A live-slot response → REPLAY.
- TLB_MISS:
  - Kill → KILL_TLB.
  - `tlb_valid_i && !tlb_miss_i` → REPLAY_TLB.
- REPLAY, REPLAY_TLB: one cycle, then READ. Kill → KILL.
- KILL, KILL_TLB: one cycle, then NO_REQ.
- Any `fill_rsp_valid_i` on a busy slot, in any state:
  - `fill_we_o`=1 and `fill_idx_o`=slot idx in the same cycle.
  - The slot frees at the next edge.
  - Stale responses are written but trigger no replay.
- A response on a non-busy ID is ignored and flagged by an assertion.
- Kill and a live response in the same cycle: kill wins and the line is still written.
- A fill response and a fill-request handshake in the same cycle never collide on a slot. A slot freed this cycle is not allocatable until the next cycle.

## Timing
- Reset values: state NO_REQ, all slots free, `req_ready_o`=1, every other output 0.
- `resp_valid_o`, `fill_req_valid_o`, `fill_we_o` and `req_ready_o` are combinational from state and inputs. State and slots are registered.
- Hit: accepted at cycle 0, `resp_valid_o` at cycle 1 (TLB valid at cycle 1).
- Miss: fill request at cycle 2 earliest. If the response arrives at cycle N: `fill_we_o` at N, REPLAY at N+1, READ and `resp_valid_o` (hit) at N+2.
- All slots busy with stale entries: MISS holds `fill_req_valid_o`=0 until a slot frees.
- `outstanding_o` updates at the edge after the handshake or response. A simultaneous allocate and free nets to no change.

## Test plan
- Hit: request idx=0x05, TLB valid at cycle 1, `hit_i`=1 → `resp_valid_o`=1 at cycle 1, then NO_REQ at cycle 2, `outstanding_o`=0.
- Miss and replay: ptag=0x12345, idx=0x05, miss → `fill_req_addr_o`=0x48D145, id 0. Response id 0 → `fill_we_o`=1 with idx 5, REPLAY then READ. Hit → `resp_valid_o`=1.
- Kill with fill outstanding (MAX_MISS=2): kill in MISS after the handshake → KILL, then NO_REQ. A new miss allocates id 1, `outstanding_o`=2. The id 0 response writes but stays in MISS. The id 1 response → REPLAY.
- Slot exhaustion: two stale misses, third miss → `fill_req_valid_o`=0 until a response frees slot 0, then the request issues with id 0.
- TLB path: `tlb_miss_i`=1 → TLB_MISS. Valid hit translation → REPLAY_TLB, READ. Repeat with a kill in TLB_MISS → KILL_TLB, then NO_REQ, no fill request.
- Async reset: assert `rstn_i`=0 mid-MISS with 2 busy slots → state 0, `outstanding_o`=0, `req_ready_o`=1 immediately.
